// File: rtl/dip_frame_sched.sv
// Frame-level capture sequencer: VS-based frame boundaries, capture-enable with drain, boundary-aligned mode switching.
// Optional DE-count frame check is built when DIP_FRAME_CHECK_EN is defined; otherwise frame_err is tied 0.
module dip_frame_sched #(
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_LAT = 3,
  parameter int FCNT_W   = 12,
  parameter int MODE_W   = 2,
  parameter int H_ACT    = 800,
  parameter int V_ACT    = 600
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic              vga_vs,
  input  logic              vga_de,
  input  logic              start,
  input  logic              abort,
  input  logic [FCNT_W-1:0] run_frames,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic [MODE_W-1:0] mode_active,
  output logic              cap_en,
  output logic              sof,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int DRN_W     = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam int PIX_TOTAL = H_ACT * V_ACT;

  typedef enum logic [2:0] {IDLE, ARM, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d;
  logic                sof_q, sof_d;
  logic [MODE_W-1:0]   mode_active_q, mode_active_d;
  logic [MODE_W-1:0]   pend_mode_q, pend_mode_d;
  logic                pend_vld_q, pend_vld_d;
  logic [FCNT_W-1:0]   target_q, target_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_inc;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic                cap_en_q, cap_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_ok;

  assign start_ok      = (state_q == IDLE) && start && (run_frames != '0);
  assign frame_cnt_inc = frame_cnt_q + 1'b1;

  always_comb begin
    vs_d          = vga_vs;
    sof_d         = (vs_q == VS_POL) && (vga_vs != VS_POL);
    mode_active_d = mode_active_q;
    pend_mode_d   = pend_mode_q;
    pend_vld_d    = pend_vld_q;
    state_d       = state_q;
    target_d      = target_q;
    frame_cnt_d   = frame_cnt_q;
    drain_d       = drain_q;
    cap_en_d      = cap_en_q;
    done_d        = 1'b0;

    // A request arriving on the boundary itself bypasses the pending slot.
    if (sof_q) begin
      if (mode_req_valid) begin
        mode_active_d = mode_req;
      end else if (pend_vld_q) begin
        mode_active_d = pend_mode_q;
      end
      pend_vld_d = 1'b0;
    end else if (mode_req_valid) begin
      pend_mode_d = mode_req;
      pend_vld_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          target_d    = run_frames;
          frame_cnt_d = '0;
          state_d     = ARM;
        end
      end
      ARM: begin
        if (sof_q) begin
          cap_en_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (sof_q) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc == target_q) begin
            drain_d = DRN_W'(PIPE_LAT);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          cap_en_d = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      cap_en_d    = 1'b0;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      drain_d     = drain_q;
    end

    busy_d = (state_d != IDLE);
  end

`ifdef DIP_FRAME_CHECK_EN
  localparam int PIX_W = $clog2(PIX_TOTAL + 1);

  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             frame_err_q, frame_err_d;

  // The ARM-to-RUN boundary is skipped: the frame before it was only partly seen.
  always_comb begin
    pix_cnt_d   = pix_cnt_q;
    frame_err_d = frame_err_q;
    if (sof_q) begin
      pix_cnt_d = '0;
    end else if (vga_de) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end
    if (start_ok) begin
      frame_err_d = 1'b0;
    end else if ((state_q == RUN) && sof_q && !abort && (pix_cnt_q != PIX_W'(PIX_TOTAL))) begin
      frame_err_d = 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  logic unused_frame_chk;
  assign unused_frame_chk = ^{vga_de, PIX_TOTAL[0]};
  assign frame_err        = 1'b0;
`endif

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      vs_q          <= ~VS_POL;
      sof_q         <= 1'b0;
      mode_active_q <= '0;
      pend_mode_q   <= '0;
      pend_vld_q    <= 1'b0;
      target_q      <= '0;
      frame_cnt_q   <= '0;
      drain_q       <= '0;
      cap_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef DIP_FRAME_CHECK_EN
      pix_cnt_q     <= '0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      sof_q         <= sof_d;
      mode_active_q <= mode_active_d;
      pend_mode_q   <= pend_mode_d;
      pend_vld_q    <= pend_vld_d;
      target_q      <= target_d;
      frame_cnt_q   <= frame_cnt_d;
      drain_q       <= drain_d;
      cap_en_q      <= cap_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef DIP_FRAME_CHECK_EN
      pix_cnt_q     <= pix_cnt_d;
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  assign mode_active = mode_active_q;
  assign cap_en      = cap_en_q;
  assign sof         = sof_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_dip_frame_sched.sv
// Self-checking bench for dip_frame_sched: small raster, directed scenarios then random pulses,
// every cycle compared against an event-level reference model.
module tb_dip_frame_sched;

  localparam bit VS_POL   = 1'b1;
  localparam int PIPE_LAT = 3;
  localparam int FCNT_W   = 12;
  localparam int MODE_W   = 2;
  localparam int H_ACT    = 8;
  localparam int V_ACT    = 4;
  localparam int H_TOT    = 12;
  localparam int V_TOT    = 7;
  localparam int BOUND    = 1000;

  logic              pixel_clk = 1'b0;
  logic              reset_n   = 1'b0;
  logic              vga_vs, vga_de, start, abort, mode_req_valid;
  logic [FCNT_W-1:0] run_frames;
  logic [MODE_W-1:0] mode_req;
  logic [MODE_W-1:0] mode_active;
  logic              cap_en, sof, busy, done, frame_err;
  logic [FCNT_W-1:0] frame_cnt;

  dip_frame_sched #(
    .VS_POL(VS_POL), .PIPE_LAT(PIPE_LAT), .FCNT_W(FCNT_W), .MODE_W(MODE_W),
    .H_ACT(H_ACT), .V_ACT(V_ACT)
  ) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .vga_vs(vga_vs), .vga_de(vga_de),
    .start(start), .abort(abort), .run_frames(run_frames), .mode_req(mode_req),
    .mode_req_valid(mode_req_valid), .mode_active(mode_active), .cap_en(cap_en),
    .sof(sof), .frame_cnt(frame_cnt), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;
  int h_pos    = 0;
  int v_pos    = 0;
  bit drop_pending = 1'b0;
  int guard;

  // Reference model: m_tail counts cycles since the final counted boundary (-1 = not draining).
  bit m_vs_prev, m_sof, m_busy, m_waiting, m_cap, m_done, m_err;
  int m_mode, m_pend, m_cnt, m_target, m_tail, m_pix;

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task modelReset();
    m_vs_prev = ~VS_POL;
    m_sof = 0; m_busy = 0; m_waiting = 0; m_cap = 0; m_done = 0; m_err = 0;
    m_mode = 0; m_pend = -1; m_cnt = 0; m_target = 0; m_tail = -1; m_pix = 0;
  endtask

  task modelEdge();
    bit boundary, was_done;
    if (!reset_n) begin
      modelReset();
      return;
    end
    boundary  = m_sof;
    m_sof     = (m_vs_prev == VS_POL) && (vga_vs != VS_POL);
    m_vs_prev = vga_vs;
    if (boundary) begin
      if (mode_req_valid) m_mode = int'(mode_req);
      else if (m_pend >= 0) m_mode = m_pend;
      m_pend = -1;
    end else if (mode_req_valid) begin
      m_pend = int'(mode_req);
    end
    was_done = m_done;
    m_done   = 0;
    if (!m_busy) begin
      if (start && run_frames != 0) begin
        m_busy = 1; m_waiting = 1; m_target = int'(run_frames); m_cnt = 0; m_tail = -1; m_err = 0;
      end
    end else if (abort) begin
      m_busy = 0; m_cap = 0; m_waiting = 0; m_tail = -1;
    end else if (was_done) begin
      m_busy = 0;
    end else if (m_tail >= 0) begin
      m_tail++;
      if (m_tail == PIPE_LAT + 1) begin
        m_cap = 0; m_done = 1; m_tail = -1;
      end
    end else if (boundary) begin
      if (m_waiting) begin
        m_waiting = 0; m_cap = 1;
      end else begin
`ifdef DIP_FRAME_CHECK_EN
        if (m_pix != H_ACT * V_ACT) m_err = 1;
`endif
        m_cnt++;
        if (m_cnt == m_target) m_tail = 0;
      end
    end
    if (boundary) m_pix = 0;
    else if (vga_de) m_pix++;
  endtask

  task checkAll();
    checkOutput("busy", busy, m_busy);
    checkOutput("cap_en", cap_en, m_cap);
    checkOutput("done", done, m_done);
    checkOutput("sof", sof, m_sof);
    checkOutput("frame_cnt", frame_cnt, m_cnt);
    checkOutput("mode_active", mode_active, m_mode);
    checkOutput("frame_err", frame_err, m_err);
  endtask

  task applyStimulus(input bit st, input int rf, input bit ab, input bit mrv, input int mreq);
    start          = st;
    run_frames     = FCNT_W'(rf);
    abort          = ab;
    mode_req_valid = mrv;
    mode_req       = MODE_W'(mreq);
    vga_vs = (v_pos == V_ACT + 1) ? VS_POL : ~VS_POL;
    vga_de = (h_pos < H_ACT) && (v_pos < V_ACT);
    if (vga_de && drop_pending) begin
      vga_de = 1'b0;
      drop_pending = 1'b0;
    end
    h_pos++;
    if (h_pos == H_TOT) begin
      h_pos = 0;
      v_pos = (v_pos + 1) % V_TOT;
    end
    @(posedge pixel_clk);
    modelEdge();
    @(negedge pixel_clk);
    checkAll();
  endtask

  task idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task waitIdle(input string tag);
    for (guard = 0; guard < BOUND && m_busy; guard++) idle(1);
    checkOutput(tag, guard < BOUND, 1);
  endtask

  initial begin
    start = 0; abort = 0; mode_req_valid = 0; run_frames = '0; mode_req = '0;
    vga_vs = ~VS_POL; vga_de = 0;
    modelReset();
    idle(4);
    reset_n = 1'b1;
    idle(20);

    // Two-frame run
    applyStimulus(1, 2, 0, 0, 0);
    waitIdle("run2_end");
    checkOutput("run2_cnt", frame_cnt, 2);

    // Mode request mid-frame, then one coincident with sof
    idle(30);
    applyStimulus(0, 0, 0, 1, 2);
    for (guard = 0; guard < BOUND && !m_sof; guard++) idle(1);
    idle(2);
    checkOutput("mode_after_sof", mode_active, 2);
    for (guard = 0; guard < BOUND && !m_sof; guard++) idle(1);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("mode_on_sof", mode_active, 3);

    // Zero-length start ignored; restart during RUN ignored
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("zero_start_busy", busy, 0);
    idle(100);
    applyStimulus(1, 2, 0, 0, 0);
    for (guard = 0; guard < BOUND && !(m_busy && !m_waiting); guard++) idle(1);
    applyStimulus(1, 5, 0, 0, 0);
    waitIdle("restart_end");
    checkOutput("restart_cnt", frame_cnt, 2);

    // Abort mid-RUN, then abort coincident with sof
    applyStimulus(1, 3, 0, 0, 0);
    for (guard = 0; guard < BOUND && m_cnt != 1; guard++) idle(1);
    idle(5);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("abort_cnt", frame_cnt, 1);
    checkOutput("abort_busy", busy, 0);
    idle(10);
    applyStimulus(1, 3, 0, 0, 0);
    for (guard = 0; guard < BOUND && !(m_sof && m_cnt == 1 && m_busy); guard++) idle(1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("abort_sof_cnt", frame_cnt, 1);
    checkOutput("abort_sof_cap", cap_en, 0);

    // Asynchronous reset mid-DRAIN, then a one-frame run
    applyStimulus(1, 2, 0, 0, 0);
    for (guard = 0; guard < BOUND && m_tail < 1; guard++) idle(1);
    #2 reset_n = 1'b0;
    #1 modelReset();
    checkAll();
    checkOutput("reset_cap", cap_en, 0);
    idle(3);
    reset_n = 1'b1;
    idle(5);
    applyStimulus(1, 1, 0, 0, 0);
    waitIdle("run1_end");
    checkOutput("run1_cnt", frame_cnt, 1);

    // Dropped DE in the second counted frame
    applyStimulus(1, 3, 0, 0, 0);
    for (guard = 0; guard < BOUND && m_cnt != 1; guard++) idle(1);
    drop_pending = 1'b1;
    waitIdle("drop_end");
`ifdef DIP_FRAME_CHECK_EN
    checkOutput("frame_err_drop", frame_err, 1);
`else
    checkOutput("frame_err_drop", frame_err, 0);
`endif
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("frame_err_clear", frame_err, 0);
    waitIdle("after_drop_end");

    // Random pulses
    repeat (4000) begin
      if ($urandom_range(0, 199) == 0) drop_pending = 1'b1;
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/dip_frame_sched.md
Name: dip_frame_sched

Overview:
Frame-level sequencer for the pixel datapath (timing generator -> colour-space pipeline -> capture sink). It detects frame boundaries from the timing generator's VS and runs a programmed number of capture frames. It holds the capture-enable for the sink, including a drain window that covers pipeline latency. Processing-mode changes take effect only at frame boundaries, so no frame ever mixes modes.

Parameters:
VS_POL, 1, active level of vga_vs (1 = active-high)
PIPE_LAT, 3, datapath latency in pixel_clk cycles, from vga_de to processed o_de
FCNT_W, 12, width of the frame counter and of run_frames
MODE_W, 2, width of the processing-mode select
H_ACT, 800, active pixels per line (frame check only)
V_ACT, 600, active lines per frame (frame check only)

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
vga_vs  in  1  vertical sync from the timing generator
vga_de  in  1  data enable from the timing generator
start  in  1  1-cycle pulse; arms a capture run
abort  in  1  1-cycle pulse; terminates a run immediately
run_frames  in  FCNT_W  number of frames to capture; sampled on an accepted start
mode_req  in  MODE_W  requested processing mode
mode_req_valid  in  1  1-cycle strobe qualifying mode_req
mode_active  out  MODE_W  mode currently applied to the datapath mux
cap_en  out  1  gates capture-sink DE (sink uses o_de & cap_en)
sof  out  1  1-cycle frame-boundary pulse
frame_cnt  out  FCNT_W  frames completed in the current or last run
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse at normal run completion
frame_err  out  1  sticky DE-count mismatch flag (optional feature)

Behaviour:
- Reset values: vs_r = ~VS_POL; mode_active = 0; pending mode empty; cap_en = 0, sof = 0, frame_cnt = 0, busy = 0, done = 0, frame_err = 0; state = IDLE.
- Frame boundary: vs_r <= vga_vs each cycle. sof = (vs_r == VS_POL) && (vga_vs != VS_POL), i.e. the deassertion edge of VS. sof is registered, so it appears 1 cycle after that edge. It is generated in every state.
- Mode handling:
  - mode_req_valid loads pend_mode and sets pend_vld; a later request before the boundary overwrites it.
  - On sof with pend_vld set: mode_active <= pend_mode and pend_vld clears.
  - If mode_req_valid and sof coincide, mode_req goes straight to mode_active and pend_vld clears.
  - Mode changes are independent of the run state.
- FSM states: IDLE, ARM, RUN, DRAIN, DONE.
  - IDLE: on start with run_frames != 0, latch target <= run_frames, clear frame_cnt, go to ARM. start with run_frames == 0 is ignored.
  - ARM: wait for sof, then go to RUN; cap_en <= 1 on that same edge.
  - RUN: each sof does frame_cnt <= frame_cnt + 1. If frame_cnt + 1 == target on that sof, go to DRAIN, load drain counter <= PIPE_LAT, and keep cap_en = 1.
  - DRAIN: decrement the counter each cycle. At 0: cap_en <= 0, go to DONE. With PIPE_LAT = 0, DRAIN lasts 1 cycle.
  - DONE: done = 1 for exactly 1 cycle, then IDLE. frame_cnt holds its final value until the next accepted start.
- start while busy is ignored; target is unchanged.
- abort in any non-IDLE state: state <= IDLE and cap_en <= 0 on the next edge. done does not pulse; frame_cnt holds. abort coincident with sof: abort wins, and the count is not incremented. abort in IDLE has no effect.
- frame_cnt arithmetic: unsigned, FCNT_W bits. Maximum run is 2^FCNT_W - 1 frames, so there is no wrap inside a legal run.
- Reset mid-run: everything returns to reset values asynchronously; the run is lost.

Optional Feature:
Macro: DIP_FRAME_CHECK_EN.
- Defined:
  - A pixel counter of width ceil(log2(H_ACT*V_ACT+1)) counts vga_de cycles; it clears on every sof.
  - At each sof in RUN, or at the sof that enters DRAIN, the count is compared to H_ACT*V_ACT. On mismatch, frame_err <= 1 (sticky).
  - frame_err clears on an accepted start.
  - The ARM-to-RUN sof performs no comparison, because that frame was partial.
- Undefined: the counter is not built and frame_err is tied 0.

Test Plan:
1. 800x600 timing, run_frames = 2, start pulse -> busy next cycle; cap_en rises with the 1st sof; frame_cnt goes 1 then 2 at the next two sofs; cap_en falls PIPE_LAT+1 = 4 cycles after the 2nd counted sof; done pulses once; frame_cnt stays 2.
2. mode_req = 2 strobed mid-frame -> mode_active stays 0 until the next sof, then becomes 2. Second case: mode_req = 3 strobed on the same cycle as sof -> mode_active = 3 that edge.
3. run_frames = 0 with start -> busy stays 0, no cap_en, no done. A second start during RUN with run_frames = 5 -> ignored; the run still ends at 2.
4. abort during RUN at frame_cnt = 1 -> next cycle state IDLE, cap_en 0, busy 0, no done, frame_cnt = 1. Second case: abort coincident with sof -> frame_cnt not incremented.
5. reset_n low for 3 cycles mid-DRAIN -> all outputs at reset values immediately. After release, start with run_frames = 1 -> normal run, done after 1 frame.
6. With DIP_FRAME_CHECK_EN defined, drop 1 DE cycle in the 2nd frame -> frame_err = 1 at that sof and held through done; the next start clears it. Without the macro, frame_err is constant 0.
